// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the two-port memory bus arbiter.
// Optional round-robin tie breaking is selected with ARB_ROUND_ROBIN_EN.
package mem_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b11
    } arb_state_t;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_DATA) ? PORT_INSTR : PORT_DATA;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Combinational grant selection between the instruction and data ports.
// With ARB_ROUND_ROBIN_EN ties alternate on last_grant, otherwise data wins.
module arb_grant_sel
    import mem_bus_pkg::*;
(
    input  logic     i_req_i,
    input  logic     d_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  port_id_t last_grant_i,
`endif
    output logic     valid_o,
    output port_id_t grant_o
);

    always_comb begin
        valid_o = i_req_i | d_req_i;
        if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_o = other_port(last_grant_i);
`else
            grant_o = PORT_DATA;
`endif
        end else if (d_req_i) begin
            grant_o = PORT_DATA;
        end else begin
            grant_o = PORT_INSTR;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one bus-master bridge between instruction and data ports, one access at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed data priority.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_write_data,
    input  logic [DATA_W/8-1:0] i_byteenable,
    input  logic                i_read,
    input  logic                i_write,
    output logic [DATA_W-1:0]   i_read_data,
    output logic                i_busy,

    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_write_data,
    input  logic [DATA_W/8-1:0] d_byteenable,
    input  logic                d_read,
    input  logic                d_write,
    output logic [DATA_W-1:0]   d_read_data,
    output logic                d_busy,

    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_write_data,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_read,
    output logic                m_write,
    input  logic [DATA_W-1:0]   m_read_data,
    input  logic                m_busy
);

    arb_state_t             state_q;
    port_id_t               grant_q;
    logic [ADDR_W-1:0]      addr_q,  addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W/8-1:0]    be_q,    be_d;
    logic                   rd_q,    rd_d;
    logic                   wr_d;
    logic [DATA_W-1:0]      i_rdata_q, d_rdata_q;

    logic                   i_vld, d_vld;
    logic                   grant_valid;
    port_id_t               grant_sel;
    logic                   complete;

    // Read and write together is not a request at all.
    assign i_vld = i_read ^ i_write;
    assign d_vld = d_read ^ d_write;

`ifdef ARB_ROUND_ROBIN_EN
    port_id_t last_grant_q;
`endif

    arb_grant_sel u_grant_sel (
        .i_req_i      (i_vld),
        .d_req_i      (d_vld),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant_i (last_grant_q),
`endif
        .valid_o      (grant_valid),
        .grant_o      (grant_sel)
    );

    always_comb begin
        if (grant_sel == PORT_DATA) begin
            addr_d  = d_address;
            wdata_d = d_write_data;
            be_d    = d_byteenable;
            rd_d    = d_read;
            wr_d    = d_write;
        end else begin
            addr_d  = i_address;
            wdata_d = i_write_data;
            be_d    = i_byteenable;
            rd_d    = i_read;
            wr_d    = i_write;
        end
    end

    always_comb begin
        m_address    = '0;
        m_write_data = '0;
        m_byteenable = '0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        i_busy       = i_vld;
        d_busy       = d_vld;
        i_read_data  = i_rdata_q;
        d_read_data  = d_rdata_q;
        complete     = 1'b0;
        // Reset abandons any grant silently: nothing issued, nothing completed.
        if (rst) begin
            i_busy = 1'b0;
            d_busy = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        m_address    = addr_d;
                        m_write_data = wdata_d;
                        m_byteenable = be_d;
                        m_read       = rd_d;
                        m_write      = wr_d;
                    end
                end
                WAIT: begin
                    m_address    = addr_q;
                    m_write_data = wdata_q;
                    m_byteenable = be_q;
                    complete     = ~m_busy;
                    if (grant_q == PORT_DATA) begin
                        d_busy = d_vld & m_busy;
                        if (complete) d_read_data = m_read_data;
                    end else begin
                        i_busy = i_vld & m_busy;
                        if (complete) i_read_data = m_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= PORT_INSTR;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= PORT_INSTR;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q <= WAIT;
                        grant_q <= grant_sel;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        rd_q    <= rd_d;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant_sel;
`endif
                    end
                end
                WAIT: begin
                    if (complete) begin
                        state_q <= IDLE;
                        if (rd_q) begin
                            if (grant_q == PORT_DATA) d_rdata_q <= m_read_data;
                            else                      i_rdata_q <= m_read_data;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a port-level model.
// Expected tie behaviour follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] i_address, i_write_data, i_read_data;
    logic [3:0]  i_byteenable;
    logic        i_read, i_write, i_busy;
    logic [31:0] d_address, d_write_data, d_read_data;
    logic [3:0]  d_byteenable;
    logic        d_read, d_write, d_busy;
    logic [31:0] m_address, m_write_data, m_read_data;
    logic [3:0]  m_byteenable;
    logic        m_read, m_write, m_busy;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_address    (i_address),
        .i_write_data (i_write_data),
        .i_byteenable (i_byteenable),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_read_data  (i_read_data),
        .i_busy       (i_busy),
        .d_address    (d_address),
        .d_write_data (d_write_data),
        .d_byteenable (d_byteenable),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_read_data  (d_read_data),
        .d_busy       (d_busy),
        .m_address    (m_address),
        .m_write_data (m_write_data),
        .m_byteenable (m_byteenable),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_read_data  (m_read_data),
        .m_busy       (m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err;
    int n_checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_check(input string tag);
        check({tag, ".m_read"},  {31'd0, m_read},  32'd0);
        check({tag, ".m_write"}, {31'd0, m_write}, 32'd0);
        check({tag, ".m_addr"},  m_address,        32'd0);
        check({tag, ".m_wdata"}, m_write_data,     32'd0);
        check({tag, ".m_be"},    {28'd0, m_byteenable}, 32'd0);
        check({tag, ".i_busy"},  {31'd0, i_busy},  32'd0);
        check({tag, ".d_busy"},  {31'd0, d_busy},  32'd0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    // Random-phase model state: index 0 = instruction port, 1 = data port.
    logic        rd [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    bit          outst [2];
    bit          vld [2];
    logic [31:0] exp_rd [2];
    logic [31:0] gold [16];
    logic [31:0] bmem [16];
    int          owner, owner_n, last, w, r, br_idx, idx, done_read_port;
    bit          br_active, own_rd;
    logic [31:0] own_ad, own_wd;
    logic [3:0]  own_be;
    logic [31:0] exp_i_rd, exp_d_rd;
    logic        obs_busy;
    logic [31:0] obs_rdata;
    bit          exp_d;

    initial begin
        n_err = 0;
        n_checks = 0;
        rst = 1'b1;
        {i_address, i_write_data, i_byteenable, i_read, i_write} = '0;
        {d_address, d_write_data, d_byteenable, d_read, d_write} = '0;
        m_read_data = '0;
        m_busy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        quiet_check("reset");
        check("reset.i_rdata", i_read_data, 32'd0);
        check("reset.d_rdata", d_read_data, 32'd0);
        nxt();

        // Single data read, zero wait states
        d_read = 1'b1; d_address = 32'h100; m_busy = 1'b0; #2;
        check("dread.req_busy", {31'd0, d_busy}, 32'd1);
        check("dread.m_read",   {31'd0, m_read}, 32'd1);
        check("dread.m_addr",   m_address, 32'h100);
        check("dread.i_busy",   {31'd0, i_busy}, 32'd0);
        nxt();
        m_read_data = 32'hDEADBEEF; #2;
        check("dread.done_busy", {31'd0, d_busy}, 32'd0);
        check("dread.done_data", d_read_data, 32'hDEADBEEF);
        check("dread.wait_mrd",  {31'd0, m_read}, 32'd0);
        check("dread.wait_addr", m_address, 32'h100);
        nxt();
        d_read = 1'b0; m_read_data = 32'h12345678; #2;
        check("dread.held",   d_read_data, 32'hDEADBEEF);
        check("dread.i_data", i_read_data, 32'd0);
        check("dread.idle_addr", m_address, 32'd0);
        nxt();

        // Instruction read with three waitrequest cycles
        i_read = 1'b1; i_address = 32'h200; m_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("iwait.busy%0d", k), {31'd0, i_busy}, 32'd1);
            if (k == 1) check("iwait.m_addr", m_address, 32'h200);
            nxt();
        end
        m_busy = 1'b0; m_read_data = 32'hCAFEF00D; #2;
        check("iwait.done_busy", {31'd0, i_busy}, 32'd0);
        check("iwait.done_data", i_read_data, 32'hCAFEF00D);
        nxt();
        i_read = 1'b0; #2;
        check("iwait.held",   i_read_data, 32'hCAFEF00D);
        check("iwait.d_data", d_read_data, 32'hDEADBEEF);
        nxt();

        // Tie: instruction read vs data write
        i_read = 1'b1; i_address = 32'h400;
        d_write = 1'b1; d_address = 32'h800; d_write_data = 32'hA5A5A5A5; d_byteenable = 4'hF;
        #2;
        check("tie.m_write", {31'd0, m_write}, 32'd1);
        check("tie.m_read",  {31'd0, m_read},  32'd0);
        check("tie.m_addr",  m_address, 32'h800);
        check("tie.m_wdata", m_write_data, 32'hA5A5A5A5);
        check("tie.m_be",    {28'd0, m_byteenable}, 32'hF);
        check("tie.i_busy",  {31'd0, i_busy}, 32'd1);
        check("tie.d_busy",  {31'd0, d_busy}, 32'd1);
        nxt();
        m_read_data = 32'h99999999; #2;
        check("tie.d_done", {31'd0, d_busy}, 32'd0);
        check("tie.i_wait", {31'd0, i_busy}, 32'd1);
        nxt();
        d_write = 1'b0; #2;
        check("tie.i_issue", {31'd0, m_read}, 32'd1);
        check("tie.i_addr",  m_address, 32'h400);
        check("tie.i_busy2", {31'd0, i_busy}, 32'd1);
        check("tie.wr_no_rdata", d_read_data, 32'hDEADBEEF);
        nxt();
        m_read_data = 32'h11112222; #2;
        check("tie.i_done", {31'd0, i_busy}, 32'd0);
        check("tie.i_data", i_read_data, 32'h11112222);
        nxt();
        i_read = 1'b0;

        // Continuous contention: four grants
        exp_i_rd = 32'h11112222;
        exp_d_rd = 32'hDEADBEEF;
        i_read = 1'b1; i_address = 32'h440;
        d_read = 1'b1; d_address = 32'h880;
        for (int g = 0; g < 4; g++) begin
            exp_d = RR ? ((g % 2) == 0) : 1'b1;
            #2;
            check($sformatf("cont.grant%0d", g), m_address, exp_d ? 32'h880 : 32'h440);
            nxt();
            m_read_data = 32'hB000_0000 + 32'(g); #2;
            if (exp_d) begin
                exp_d_rd = m_read_data;
                check($sformatf("cont.d_data%0d", g), d_read_data, exp_d_rd);
                check($sformatf("cont.i_stall%0d", g), {31'd0, i_busy}, 32'd1);
            end else begin
                exp_i_rd = m_read_data;
                check($sformatf("cont.i_data%0d", g), i_read_data, exp_i_rd);
                check($sformatf("cont.d_stall%0d", g), {31'd0, d_busy}, 32'd1);
            end
            nxt();
        end
        i_read = 1'b0; d_read = 1'b0; #2;
        check("cont.i_held", i_read_data, exp_i_rd);
        check("cont.d_held", d_read_data, exp_d_rd);
        nxt();

        // Read and write together is no request
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h123;
        for (int k = 0; k < 2; k++) begin
            #2;
            quiet_check($sformatf("both%0d", k));
            nxt();
        end
        d_read = 1'b0; d_write = 1'b0;

        // Reset during WAIT
        d_read = 1'b1; d_address = 32'h300; #2;
        check("rstw.issue", {31'd0, m_read}, 32'd1);
        nxt();
        rst = 1'b1; m_busy = 1'b0; m_read_data = 32'h55555555; #2;
        check("rstw.no_done", d_read_data, exp_d_rd);
        check("rstw.m_read",  {31'd0, m_read}, 32'd0);
        nxt();
        rst = 1'b0; d_read = 1'b0; #2;
        quiet_check("rstw.after");
        check("rstw.i_rdata", i_read_data, 32'd0);
        check("rstw.d_rdata", d_read_data, 32'd0);
        nxt();

        // Randomized traffic against the port-level model
        for (int k = 0; k < 16; k++) begin
            gold[k] = '0;
            bmem[k] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            rd[p] = 0; wr[p] = 0; ad[p] = '0; wd[p] = '0; be[p] = '0;
            outst[p] = 0; exp_rd[p] = '0;
        end
        owner = -1; last = 0; br_active = 0; br_idx = 0;
        own_rd = 0; own_ad = '0; own_wd = '0; own_be = '0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!outst[p]) begin
                    r = $urandom_range(0, 9);
                    rd[p] = 1'b0; wr[p] = 1'b0;
                    if (r >= 5) begin
                        ad[p] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                        wd[p] = $urandom;
                        be[p] = 4'($urandom);
                        if (r <= 6)      rd[p] = 1'b1;
                        else if (r <= 8) wr[p] = 1'b1;
                        else begin rd[p] = 1'b1; wr[p] = 1'b1; end
                        outst[p] = (r <= 8);
                    end
                end
            end
            i_read = rd[0]; i_write = wr[0]; i_address = ad[0];
            i_write_data = wd[0]; i_byteenable = be[0];
            d_read = rd[1]; d_write = wr[1]; d_address = ad[1];
            d_write_data = wd[1]; d_byteenable = be[1];
            m_busy = ($urandom_range(0, 1) == 1);
            m_read_data = br_active ? bmem[br_idx] : $urandom;
            #2;

            for (int p = 0; p < 2; p++) vld[p] = rd[p] ^ wr[p];
            owner_n = owner;
            done_read_port = -1;
            if (owner < 0) begin
                if (vld[0] || vld[1]) begin
                    if (vld[0] && vld[1]) w = RR ? (1 - last) : 1;
                    else                  w = vld[1] ? 1 : 0;
                    check("rnd.m_read",  {31'd0, m_read},  {31'd0, rd[w]});
                    check("rnd.m_write", {31'd0, m_write}, {31'd0, wr[w]});
                    check("rnd.m_addr",  m_address, ad[w]);
                    check("rnd.m_wdata", m_write_data, wd[w]);
                    check("rnd.m_be",    {28'd0, m_byteenable}, {28'd0, be[w]});
                    owner_n = w; last = w;
                    own_rd = rd[w]; own_ad = ad[w]; own_wd = wd[w]; own_be = be[w];
                end else begin
                    check("rnd.idle_rd",   {31'd0, m_read},  32'd0);
                    check("rnd.idle_wr",   {31'd0, m_write}, 32'd0);
                    check("rnd.idle_addr", m_address, 32'd0);
                end
                for (int p = 0; p < 2; p++) begin
                    obs_busy = p ? d_busy : i_busy;
                    check($sformatf("rnd.idle_busy%0d", p), {31'd0, obs_busy}, {31'd0, vld[p]});
                end
            end else begin
                check("rnd.wait_rd",   {31'd0, m_read},  32'd0);
                check("rnd.wait_wr",   {31'd0, m_write}, 32'd0);
                check("rnd.wait_addr", m_address, own_ad);
                for (int p = 0; p < 2; p++) begin
                    obs_busy = p ? d_busy : i_busy;
                    if (p == owner)
                        check($sformatf("rnd.own_busy%0d", p), {31'd0, obs_busy}, {31'd0, m_busy});
                    else
                        check($sformatf("rnd.oth_busy%0d", p), {31'd0, obs_busy}, {31'd0, vld[p]});
                end
                if (!m_busy) begin
                    idx = int'(own_ad[5:2]);
                    if (own_rd) begin
                        obs_rdata = owner ? d_read_data : i_read_data;
                        check($sformatf("rnd.rdata%0d", owner), obs_rdata, gold[idx]);
                        exp_rd[owner] = gold[idx];
                        done_read_port = owner;
                    end else begin
                        gold[idx] = merge(gold[idx], own_wd, own_be);
                        done_read_port = owner;
                    end
                    outst[owner] = 0;
                    owner_n = -1;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (p != done_read_port) begin
                    obs_rdata = p ? d_read_data : i_read_data;
                    check($sformatf("rnd.rdata_hold%0d", p), obs_rdata, exp_rd[p]);
                end
            end

            // Bridge: accept on strobe, finish when busy drops
            if (m_read || m_write) begin
                br_active = 1;
                br_idx = int'(m_address[5:2]);
                if (m_write) bmem[br_idx] = merge(bmem[br_idx], m_write_data, m_byteenable);
            end else if (br_active && !m_busy) begin
                br_active = 0;
            end
            owner = owner_n;
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
